data_mem_arbiter: RTL
=====================

Name: data_mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the byte-addressed data memory (combinational read, posedge write, 3-bit Size encoding).
- Port 0 is the core load/store unit. Port 1 is the program/debug loader.
- Grants one request per cycle using round-robin, registers the winning command, and drives it to memory in the next cycle.
- Returns a one-cycle response pulse to the owner one cycle after that.

Parameters:
- ADDR_WIDTH, 32, address width on all ports.
- BYTE_SIZE, 4, data bytes per word; DW = BYTE_SIZE*8.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- p0_req, p1_req  in  1  command valid; held until granted.
- p0_we, p1_we  in  1  1=store, 0=load.
- p0_size, p1_size  in  3  000 word, 001 signed half, 010 unsigned half, 011 signed byte, 100 unsigned byte.
- p0_addr, p1_addr  in  ADDR_WIDTH  byte address.
- p0_wd, p1_wd  in  DW  store data.
- p0_gnt, p1_gnt  out  1  command accepted this cycle.
- p0_rvalid, p1_rvalid  out  1  one-cycle response pulse, for both loads and stores.
- p0_rdata, p1_rdata  out  DW  load data; 0 for stores.
- p0_rerr, p1_rerr  out  1  response error; valid with rvalid.
- mem_we  out  1  memory write enable.
- mem_size  out  3  memory Size.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wd  out  DW  memory write data.
- mem_rd  in  DW  memory read data (combinational from mem_addr/mem_size).

Behaviour:
- Reset: all outputs 0. Command stage and response stage are empty. rr_ptr = 0 (port 0 has priority).
- Asynchronous reset asserted mid-access forces mem_we low immediately; a store in flight may be lost. The pending response is discarded (no rvalid).

Pipeline stages:
- Stage A (cycle N):
  - Arbitration is combinational over p0_req/p1_req.
  - Exactly one gnt is high for the winner; gnt is never high without req.
  - Winner's we/size/addr/wd and owner id are captured into the command register at the edge ending N.
- Stage B (cycle N+1):
  - mem_* are driven from the command register; mem_we = cmd_we.
  - The store commits at the edge ending N+1.
  - For a load, mem_rd is captured into the response register at that edge.
- Stage C (cycle N+2):
  - owner's rvalid = 1 for exactly one cycle.
  - rdata = captured load data (0 for store); rerr as defined below.
  - Non-owner rvalid/rdata/rerr = 0.

Throughput and ordering:
- Full throughput: a new grant is allowed every cycle, independent of stages B/C occupancy. There is no backpressure on responses.
- Store followed by load to the same address on back-to-back grants: the load sees the new data, because the write commits before the load's stage B.

Arbitration:
- Only one requester: it wins every cycle it requests.
- Both requesting: the port indicated by rr_ptr wins. After any grant, rr_ptr = ~winner.
- Continuous requests from both ports alternate 0,1,0,1...

Rules:
- Requester keeps req and command fields stable while req=1 and gnt=0. Dropping req before gnt is allowed; no grant results.
- Stage B empty: mem_we=0, mem_size=000, mem_addr=0, mem_wd=0.
- Size values 101-111 pass through unchanged. Memory returns 0 for loads and ignores stores; rerr=1 on the response.
- Store with size 010/100: forwarded unchanged; memory ignores it; rerr=0.
- Address arithmetic is not checked for wrap at memory top; addr is forwarded verbatim.

Optional Feature:
- Macro DATA_MEM_ARB_ALIGN_CHECK_EN.
- Defined:
  - Word with addr[1:0]!=0, or half-word with addr[0]!=0, is flagged in stage A.
  - In stage B it is not issued: mem_we=0, mem_* idle values.
  - Response in stage C: rvalid=1, rerr=1, rdata=0.
- Undefined: misaligned commands are forwarded unchanged; rerr is set only for illegal Size.

Test Plan:
- Reset, then p0 store word 0xDEADBEEF @0x10, then p0 load word @0x10:
  - gnts on consecutive cycles.
  - load p0_rvalid at gnt+2 with p0_rdata=0xDEADBEEF, rerr=0.
- p1 store byte 0x80 @0x21, then load size 011 @0x21 → rdata=0xFFFFFF80; load size 100 @0x21 → rdata=0x00000080.
- p0 and p1 both hold req for 6 cycles:
  - gnt sequence p0,p1,p0,p1,p0,p1.
  - responses arrive to the matching owner 2 cycles after each gnt.
- Load size 101 @0x00 → rvalid=1, rerr=1, rdata=0. p0 store half 0x1234 size 010 → memory unchanged.
- rst_n pulled low during a store's stage B:
  - mem_we falls immediately, no rvalid, all outputs 0.
  - after release, p0 wins the first contested cycle.
- With DATA_MEM_ARB_ALIGN_CHECK_EN: store word @0x02 → mem_we never asserts, rerr=1. Without the macro: the write occurs and rerr=0.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//
// Purpose:
//   Two-requester arbiter and sequencer in front of the byte-addressed data
//   memory. Port 0 is the core load/store unit, port 1 the program/debug
//   loader. One request is granted per cycle (round-robin when both ask).
//   The winning command is registered (stage A -> B), driven to the memory
//   in stage B, and a one-cycle response pulse is returned to the owner in
//   stage C. Full throughput, no backpressure.
//
// Optional feature:
//   DATA_MEM_ARB_ALIGN_CHECK_EN - when defined, misaligned word/half commands
//   are flagged at grant, never issued to memory, and answered with rerr=1.
//   When undefined, misaligned commands are forwarded unchanged.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   pX_req/we/size/addr/wd  command from requester X (held until granted)
//   pX_gnt                command accepted this cycle
//   pX_rvalid/rdata/rerr  one-cycle response to requester X
//   mem_we/size/addr/wd   command to memory (idle values when stage B empty)
//   mem_rd                combinational read data from memory
//
// Size encoding: 000 word, 001 signed half, 010 unsigned half,
//                011 signed byte, 100 unsigned byte, 101-111 illegal.
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int BYTE_SIZE  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // requester 0 (load/store unit)
  input  logic                    p0_req,
  input  logic                    p0_we,
  input  logic [2:0]              p0_size,
  input  logic [ADDR_WIDTH-1:0]   p0_addr,
  input  logic [BYTE_SIZE*8-1:0]  p0_wd,
  output logic                    p0_gnt,
  output logic                    p0_rvalid,
  output logic [BYTE_SIZE*8-1:0]  p0_rdata,
  output logic                    p0_rerr,
  // requester 1 (program/debug loader)
  input  logic                    p1_req,
  input  logic                    p1_we,
  input  logic [2:0]              p1_size,
  input  logic [ADDR_WIDTH-1:0]   p1_addr,
  input  logic [BYTE_SIZE*8-1:0]  p1_wd,
  output logic                    p1_gnt,
  output logic                    p1_rvalid,
  output logic [BYTE_SIZE*8-1:0]  p1_rdata,
  output logic                    p1_rerr,
  // data memory
  output logic                    mem_we,
  output logic [2:0]              mem_size,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [BYTE_SIZE*8-1:0]  mem_wd,
  input  logic [BYTE_SIZE*8-1:0]  mem_rd
);

  localparam int DW = BYTE_SIZE * 8;

  localparam logic [2:0] SZ_WORD  = 3'b000;
  localparam logic [2:0] SZ_SHALF = 3'b001;
  localparam logic [2:0] SZ_UHALF = 3'b010;
  localparam logic [2:0] SZ_UBYTE = 3'b100;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // Round-robin pointer: 0 -> port 0 wins a contested cycle, 1 -> port 1.
  logic                  r_rrPtr;

  // Command register (stage B contents)
  logic                  r_cmdValid;
  logic                  r_cmdOwner;
  logic                  r_cmdWe;
  logic [2:0]            r_cmdSize;
  logic [ADDR_WIDTH-1:0] r_cmdAddr;
  logic [DW-1:0]         r_cmdWd;

  // Response register (stage C contents)
  logic                  r_rspValid;
  logic                  r_rspOwner;
  logic [DW-1:0]         r_rspData;
  logic                  r_rspErr;

  // ---------------------------------------------------------------------------
  // Stage A wires
  // ---------------------------------------------------------------------------
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_anyGnt;
  logic                  w_aWe;
  logic [2:0]            w_aSize;
  logic [ADDR_WIDTH-1:0] w_aAddr;
  logic [DW-1:0]         w_aWd;

  // Stage B wires
  logic                  w_cmdMisalign;
  logic                  w_issue;
  logic                  w_sizeLegal;
  logic                  w_bErr;
  logic                  w_bLoadData;

  // ---------------------------------------------------------------------------
  // Stage A: combinational arbitration.
  // Grants are held low during reset so every output reads 0 while rst_n is
  // asserted, even if requesters keep their req lines high.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (rst_n) begin
      if (p0_req && (!p1_req || !r_rrPtr)) begin
        w_gnt0 = 1'b1;
      end else if (p1_req) begin
        w_gnt1 = 1'b1;
      end
    end
  end

  assign w_anyGnt = w_gnt0 | w_gnt1;
  assign p0_gnt   = w_gnt0;
  assign p1_gnt   = w_gnt1;

  // Winner's command fields; port 0 is the default when nobody is granted,
  // which does not matter because nothing is captured then.
  always_comb begin
    w_aWe   = p0_we;
    w_aSize = p0_size;
    w_aAddr = p0_addr;
    w_aWd   = p0_wd;
    if (w_gnt1) begin
      w_aWe   = p1_we;
      w_aSize = p1_size;
      w_aAddr = p1_addr;
      w_aWd   = p1_wd;
    end
  end

  // Pointer always points away from the last winner; idle cycles keep it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rrPtr <= 1'b0;
    end else if (w_anyGnt) begin
      r_rrPtr <= w_gnt0;
    end
  end

  // Command register: valid follows the grant every cycle, the payload is
  // only loaded on a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmdValid <= 1'b0;
      r_cmdOwner <= 1'b0;
      r_cmdWe    <= 1'b0;
      r_cmdSize  <= 3'b000;
      r_cmdAddr  <= '0;
      r_cmdWd    <= '0;
    end else begin
      r_cmdValid <= w_anyGnt;
      if (w_anyGnt) begin
        r_cmdOwner <= w_gnt1;
        r_cmdWe    <= w_aWe;
        r_cmdSize  <= w_aSize;
        r_cmdAddr  <= w_aAddr;
        r_cmdWd    <= w_aWd;
      end
    end
  end

`ifdef DATA_MEM_ARB_ALIGN_CHECK_EN
  // Misalignment is decided at grant time and travels with the command.
  logic w_aMisalign;
  logic r_cmdMisalign;

  always_comb begin
    w_aMisalign = 1'b0;
    if (w_aSize == SZ_WORD) begin
      w_aMisalign = (w_aAddr[1:0] != 2'b00);
    end else if ((w_aSize == SZ_SHALF) || (w_aSize == SZ_UHALF)) begin
      w_aMisalign = w_aAddr[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmdMisalign <= 1'b0;
    end else if (w_anyGnt) begin
      r_cmdMisalign <= w_aMisalign;
    end
  end

  assign w_cmdMisalign = r_cmdMisalign;
`else
  assign w_cmdMisalign = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Stage B: drive memory from the command register.
  // A suppressed (misaligned) command leaves the memory bus idle but still
  // produces a response.
  // ---------------------------------------------------------------------------
  assign w_issue     = r_cmdValid & ~w_cmdMisalign;
  assign w_sizeLegal = (r_cmdSize <= SZ_UBYTE);
  assign w_bErr      = ~w_sizeLegal | w_cmdMisalign;
  assign w_bLoadData = w_issue & ~r_cmdWe & w_sizeLegal;

  assign mem_we   = w_issue & r_cmdWe;
  assign mem_size = w_issue ? r_cmdSize : 3'b000;
  assign mem_addr = w_issue ? r_cmdAddr : '0;
  assign mem_wd   = w_issue ? r_cmdWd   : '0;

  // Response register: load data is captured at the same edge that commits
  // a store, so a store followed by a load to the same address is coherent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rspValid <= 1'b0;
      r_rspOwner <= 1'b0;
      r_rspData  <= '0;
      r_rspErr   <= 1'b0;
    end else begin
      r_rspValid <= r_cmdValid;
      r_rspOwner <= r_cmdOwner;
      r_rspErr   <= r_cmdValid & w_bErr;
      r_rspData  <= w_bLoadData ? mem_rd : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage C: route the response to its owner only.
  // ---------------------------------------------------------------------------
  assign p0_rvalid = r_rspValid & ~r_rspOwner;
  assign p1_rvalid = r_rspValid &  r_rspOwner;
  assign p0_rdata  = p0_rvalid ? r_rspData : '0;
  assign p1_rdata  = p1_rvalid ? r_rspData : '0;
  assign p0_rerr   = p0_rvalid & r_rspErr;
  assign p1_rerr   = p1_rvalid & r_rspErr;

  // ---------------------------------------------------------------------------
  // Protocol invariants
  // ---------------------------------------------------------------------------
  gntOneHot: assert property (@(posedge clk) disable iff (!rst_n)
    !(p0_gnt && p1_gnt));
  gntNeedsReq: assert property (@(posedge clk) disable iff (!rst_n)
    (!p0_gnt || p0_req) && (!p1_gnt || p1_req));
  rvalidOneHot: assert property (@(posedge clk) disable iff (!rst_n)
    !(p0_rvalid && p1_rvalid));

endmodule
